// File: rtl/rename_regfile_if.sv
// rename_regfile_if: bundles the decoder, operand, ROB-search, commit and flush signals of the
// rename register file.
//   slave  modport : register-file side (consumes decode/commit/search results, drives operands)
//   master modport : environment side (decoder + ROB)
// Parameter ROB_WIDTH : ROB tag width.
interface rename_regfile_if #(
    parameter int unsigned ROB_WIDTH = 4
) ();
    logic                 dec_ready;
    logic [4:0]           dec_rd;
    logic [ROB_WIDTH-1:0] dec_rob_id;
    logic [4:0]           rs1_id;
    logic [4:0]           rs2_id;
    logic [31:0]          op1_val;
    logic [31:0]          op2_val;
    logic                 op1_ready;
    logic                 op2_ready;
    logic [ROB_WIDTH-1:0] op1_dep;
    logic [ROB_WIDTH-1:0] op2_dep;
    logic [ROB_WIDTH-1:0] search_rob_id_1;
    logic [ROB_WIDTH-1:0] search_rob_id_2;
    logic                 search_ready_1;
    logic                 search_ready_2;
    logic [31:0]          search_val_1;
    logic [31:0]          search_val_2;
    logic                 commit_ready;
    logic [ROB_WIDTH-1:0] commit_rob_id;
    logic [4:0]           commit_reg_id;
    logic [31:0]          commit_val;
    logic                 clear;

    modport slave (
        input  dec_ready, dec_rd, dec_rob_id, rs1_id, rs2_id,
        input  search_ready_1, search_ready_2, search_val_1, search_val_2,
        input  commit_ready, commit_rob_id, commit_reg_id, commit_val, clear,
        output op1_val, op2_val, op1_ready, op2_ready, op1_dep, op2_dep,
        output search_rob_id_1, search_rob_id_2
    );

    modport master (
        output dec_ready, dec_rd, dec_rob_id, rs1_id, rs2_id,
        output search_ready_1, search_ready_2, search_val_1, search_val_2,
        output commit_ready, commit_rob_id, commit_reg_id, commit_val, clear,
        input  op1_val, op2_val, op1_ready, op2_ready, op1_dep, op2_dep,
        input  search_rob_id_1, search_rob_id_2
    );
endinterface

// File: rtl/rename_regfile.sv
// rename_regfile: architectural register file plus register-status (rename) table.
// Tracks which ROB entry produces each register and resolves two source operands to either a
// value or a ROB tag, using the ROB search ports and a same-cycle commit bypass.
// Ports:
//   clk_in    : clock
//   rst_n_in  : asynchronous active-low reset
//   rdy_in    : global ready, state frozen when low
//   bus       : rename_regfile_if.slave (decode, operands, search, commit, clear)
// Optional feature (macro RF_DEBUG_PORT_EN): dbg_reg_id_i in, dbg_reg_val_o / dbg_busy_o /
// dbg_tag_o out, a combinational view of one register's value, busy bit and tag.
module rename_regfile #(
    parameter int unsigned ROB_WIDTH = 4
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 rdy_in,
    rename_regfile_if.slave      bus
`ifdef RF_DEBUG_PORT_EN
    ,
    input  logic [4:0]           dbg_reg_id_i,
    output logic [31:0]          dbg_reg_val_o,
    output logic                 dbg_busy_o,
    output logic [ROB_WIDTH-1:0] dbg_tag_o
`endif
);

    typedef struct packed {
        logic [31:0]          val;
        logic                 ready;
        logic [ROB_WIDTH-1:0] dep;
    } op_t;

    logic [31:0]          regs_q [32];
    logic [31:0]          regs_d [32];
    logic [31:0]          busy_q;
    logic [31:0]          busy_d;
    logic [ROB_WIDTH-1:0] tag_q  [32];
    logic [ROB_WIDTH-1:0] tag_d  [32];

    op_t op1;
    op_t op2;

    // Priority: x0, idle register, commit bypass (ROB entry already retired so search would
    // miss it), ROB search hit, otherwise wait on the tag.
    function automatic op_t lookup(input logic [4:0] rs, input logic sready,
                                   input logic [31:0] sval);
        op_t r;
        r = '{val: 32'd0, ready: 1'b1, dep: '0};
        if (rs == 5'd0) begin
            r.val = 32'd0;
        end else if (!busy_q[rs]) begin
            r.val = regs_q[rs];
        end else if (bus.commit_ready && (bus.commit_rob_id == tag_q[rs])) begin
            r.val = bus.commit_val;
        end else if (sready) begin
            r.val = sval;
        end else begin
            r.ready = 1'b0;
            r.dep   = tag_q[rs];
        end
        return r;
    endfunction

    always_comb begin
        op1 = lookup(bus.rs1_id, bus.search_ready_1, bus.search_val_1);
        op2 = lookup(bus.rs2_id, bus.search_ready_2, bus.search_val_2);
    end

    assign bus.op1_val         = op1.val;
    assign bus.op1_ready       = op1.ready;
    assign bus.op1_dep         = op1.dep;
    assign bus.op2_val         = op2.val;
    assign bus.op2_ready       = op2.ready;
    assign bus.op2_dep         = op2.dep;
    assign bus.search_rob_id_1 = tag_q[bus.rs1_id];
    assign bus.search_rob_id_2 = tag_q[bus.rs2_id];

    // Later assignments win: a same-cycle rename overrides the commit's busy clear, and a flush
    // overrides the rename (which is also gated off by clear).
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        tag_d  = tag_q;
        if (rdy_in) begin
            if (bus.commit_ready && (bus.commit_reg_id != 5'd0)) begin
                regs_d[bus.commit_reg_id] = bus.commit_val;
                if (tag_q[bus.commit_reg_id] == bus.commit_rob_id) begin
                    busy_d[bus.commit_reg_id] = 1'b0;
                end
            end
            if (bus.dec_ready && (bus.dec_rd != 5'd0) && !bus.clear) begin
                busy_d[bus.dec_rd] = 1'b1;
                tag_d[bus.dec_rd]  = bus.dec_rob_id;
            end
            if (bus.clear) begin
                busy_d = '0;
                for (int i = 0; i < 32; i++) begin
                    tag_d[i] = '0;
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            busy_q <= '0;
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= 32'd0;
                tag_q[i]  <= '0;
            end
        end else begin
            busy_q <= busy_d;
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= regs_d[i];
                tag_q[i]  <= tag_d[i];
            end
        end
    end

`ifdef RF_DEBUG_PORT_EN
    always_comb begin
        dbg_reg_val_o = 32'd0;
        dbg_busy_o    = 1'b0;
        dbg_tag_o     = '0;
        if (dbg_reg_id_i != 5'd0) begin
            dbg_reg_val_o = regs_q[dbg_reg_id_i];
            dbg_busy_o    = busy_q[dbg_reg_id_i];
            dbg_tag_o     = tag_q[dbg_reg_id_i];
        end
    end
`endif

endmodule

// File: tb/tb_rename_regfile.sv
// tb_rename_regfile: directed self-checking bench for rename_regfile.
module tb_rename_regfile;

    logic clk;
    logic rst_n;
    logic rdy;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    rename_regfile_if #(.ROB_WIDTH(4)) bus ();

`ifdef RF_DEBUG_PORT_EN
    logic [4:0]  dbg_reg_id;
    logic [31:0] dbg_reg_val;
    logic        dbg_busy;
    logic [3:0]  dbg_tag;
    assign dbg_reg_id = 5'd0;
`endif

    rename_regfile #(.ROB_WIDTH(4)) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .rdy_in   (rdy),
        .bus      (bus.slave)
`ifdef RF_DEBUG_PORT_EN
        ,
        .dbg_reg_id_i  (dbg_reg_id),
        .dbg_reg_val_o (dbg_reg_val),
        .dbg_busy_o    (dbg_busy),
        .dbg_tag_o     (dbg_tag)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic idle();
        bus.dec_ready      = 1'b0;
        bus.dec_rd         = 5'd0;
        bus.dec_rob_id     = 4'd0;
        bus.search_ready_1 = 1'b0;
        bus.search_ready_2 = 1'b0;
        bus.search_val_1   = 32'd0;
        bus.search_val_2   = 32'd0;
        bus.commit_ready   = 1'b0;
        bus.commit_rob_id  = 4'd0;
        bus.commit_reg_id  = 5'd0;
        bus.commit_val     = 32'd0;
        bus.clear          = 1'b0;
    endtask

    // Advance one clock; inputs are changed 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rename(input logic [4:0] rd, input logic [3:0] id);
        bus.dec_ready  = 1'b1;
        bus.dec_rd     = rd;
        bus.dec_rob_id = id;
        tick();
        bus.dec_ready  = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        rdy   = 1'b1;
        idle();
        bus.rs1_id = 5'd5;
        bus.rs2_id = 5'd0;
        #2;
        check("rst_op1_val",   bus.op1_val, 32'd0);
        check("rst_op1_ready", {31'd0, bus.op1_ready}, 32'd1);
        check("rst_op1_dep",   {28'd0, bus.op1_dep}, 32'd0);
        check("rst_srch1",     {28'd0, bus.search_rob_id_1}, 32'd0);
        check("rst_op2_ready", {31'd0, bus.op2_ready}, 32'd1);
        rst_n = 1'b1;
        tick();

        // Rename x5 -> tag 3; lookup in the renaming cycle sees old state.
        bus.dec_ready  = 1'b1;
        bus.dec_rd     = 5'd5;
        bus.dec_rob_id = 4'd3;
        #1;
        check("pre_ren_ready", {31'd0, bus.op1_ready}, 32'd1);
        tick();
        bus.dec_ready = 1'b0;
        #1;
        check("busy_ready", {31'd0, bus.op1_ready}, 32'd0);
        check("busy_dep",   {28'd0, bus.op1_dep}, 32'd3);
        check("busy_srch",  {28'd0, bus.search_rob_id_1}, 32'd3);
        bus.search_ready_1 = 1'b1;
        bus.search_val_1   = 32'h1234;
        #1;
        check("srch_ready", {31'd0, bus.op1_ready}, 32'd1);
        check("srch_val",   bus.op1_val, 32'h1234);
        check("srch_dep",   {28'd0, bus.op1_dep}, 32'd0);

        // Commit bypass with ROB search not ready.
        bus.search_ready_1 = 1'b0;
        bus.commit_ready   = 1'b1;
        bus.commit_rob_id  = 4'd3;
        bus.commit_reg_id  = 5'd5;
        bus.commit_val     = 32'hABCD;
        #1;
        check("byp_ready", {31'd0, bus.op1_ready}, 32'd1);
        check("byp_val",   bus.op1_val, 32'hABCD);
        tick();
        idle();
        #1;
        check("cmt_ready", {31'd0, bus.op1_ready}, 32'd1);
        check("cmt_val",   bus.op1_val, 32'hABCD);

        // x5 tag 3, then rename to 7 together with commit of tag 3.
        rename(5'd5, 4'd3);
        bus.dec_ready     = 1'b1;
        bus.dec_rd        = 5'd5;
        bus.dec_rob_id    = 4'd7;
        bus.commit_ready  = 1'b1;
        bus.commit_rob_id = 4'd3;
        bus.commit_reg_id = 5'd5;
        bus.commit_val    = 32'h5555;
        tick();
        idle();
        #1;
        check("rc_ready", {31'd0, bus.op1_ready}, 32'd0);
        check("rc_dep",   {28'd0, bus.op1_dep}, 32'd7);
        check("rc_srch",  {28'd0, bus.search_rob_id_1}, 32'd7);
        bus.commit_ready  = 1'b1;
        bus.commit_rob_id = 4'd7;
        bus.commit_reg_id = 5'd5;
        bus.commit_val    = 32'h7777;
        tick();
        idle();
        #1;
        check("c7_ready", {31'd0, bus.op1_ready}, 32'd1);
        check("c7_val",   bus.op1_val, 32'h7777);

        // Stale-tag commit writes the value but keeps busy.
        rename(5'd8, 4'd9);
        bus.commit_ready  = 1'b1;
        bus.commit_rob_id = 4'd4;
        bus.commit_reg_id = 5'd8;
        bus.commit_val    = 32'h88;
        tick();
        idle();
        bus.rs1_id = 5'd8;
        #1;
        check("stale_ready", {31'd0, bus.op1_ready}, 32'd0);
        check("stale_dep",   {28'd0, bus.op1_dep}, 32'd9);

        // Rename x1..x4, then flush with a dropped rename of x6.
        for (int i = 1; i <= 4; i++) begin
            rename(5'(i), 4'(i));
        end
        bus.rs1_id = 5'd3;
        bus.rs2_id = 5'd4;
        #1;
        check("pre_fl_dep1", {28'd0, bus.op1_dep}, 32'd3);
        check("pre_fl_dep2", {28'd0, bus.op2_dep}, 32'd4);
        bus.clear      = 1'b1;
        bus.dec_ready  = 1'b1;
        bus.dec_rd     = 5'd6;
        bus.dec_rob_id = 4'd5;
        tick();
        idle();
        for (int i = 1; i <= 6; i++) begin
            bus.rs1_id = 5'(i);
            #1;
            check($sformatf("fl_ready_x%0d", i), {31'd0, bus.op1_ready}, 32'd1);
            check($sformatf("fl_srch_x%0d", i), {28'd0, bus.search_rob_id_1}, 32'd0);
        end
        bus.rs1_id = 5'd8;
        #1;
        check("fl_x8_val", bus.op1_val, 32'h88);
        bus.rs2_id = 5'd5;
        #1;
        check("fl_x5_val", bus.op2_val, 32'h7777);

        // rdy low freezes state.
        rdy = 1'b0;
        rename(5'd9, 4'd2);
        rdy = 1'b1;
        bus.rs1_id = 5'd9;
        #1;
        check("rdy_lo_ready", {31'd0, bus.op1_ready}, 32'd1);

        // x0 is never renamed or written.
        bus.rs1_id        = 5'd0;
        bus.dec_ready     = 1'b1;
        bus.dec_rd        = 5'd0;
        bus.dec_rob_id    = 4'd2;
        bus.commit_ready  = 1'b1;
        bus.commit_rob_id = 4'd2;
        bus.commit_reg_id = 5'd0;
        bus.commit_val    = 32'hFF;
        #1;
        check("x0_same_val", bus.op1_val, 32'd0);
        tick();
        idle();
        #1;
        check("x0_val",   bus.op1_val, 32'd0);
        check("x0_ready", {31'd0, bus.op1_ready}, 32'd1);
        check("x0_srch",  {28'd0, bus.search_rob_id_1}, 32'd0);

        // Async reset mid-operation drops a pending rename.
        rename(5'd10, 4'd6);
        bus.rs1_id = 5'd10;
        #1;
        check("pre_rst_dep", {28'd0, bus.op1_dep}, 32'd6);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", {31'd0, bus.op1_ready}, 32'd1);
        check("mid_rst_x5",    {31'd0, bus.op2_ready} ^ 32'd1 | bus.op2_val, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
